// File: rtl/tx_frame_serializer_if.sv
// Word handshake between a producer and tx_frame_serializer.
interface tx_frame_serializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/tx_frame_serializer.sv
// Serializes one word per frame (preamble, start, data, [parity], stop) on bit-clock ticks.
// Optional even-parity bit after the data field when TX_PARITY_EN is defined.
module tx_frame_serializer #(
    parameter int unsigned           DATA_W     = 8,
    parameter int unsigned           PREAMBLE_W = 8,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 8'hAA
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 bit_clk_in,
    tx_frame_serializer_if.slave bus,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned MAX_W = (PREAMBLE_W > DATA_W) ? PREAMBLE_W : DATA_W;
    localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    // State names the field emitted on the next tick; PRE before its first tick is the post-accept wait.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
`ifdef TX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd4;
`endif
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              bit_clk_q;
    logic              tick_c;
    logic              accept_c;
`ifdef TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign tick_c   = bit_clk_in & ~bit_clk_q;
    assign accept_c = bus.data_valid & ready_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            bit_clk_q <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            bit_clk_q <= bit_clk_in;
`ifdef TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state: everything except the handshake advances only on a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = (state_q == S_IDLE) && !accept_c;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    shreg_d = bus.data_in;
                    cnt_d   = CNT_W'(PREAMBLE_W - 1);
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_PRE;
`ifdef TX_PARITY_EN
                    parity_d = ^bus.data_in;
`endif
                end
            end
            S_PRE: begin
                if (tick_c) begin
                    tx_d = PREAMBLE[cnt_q];
                    if (cnt_q == '0) begin
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_START: begin
                if (tick_c) begin
                    tx_d    = 1'b1;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    tx_d    = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                    if (cnt_q == '0) begin
`ifdef TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PAR: begin
                if (tick_c) begin
                    tx_d    = parity_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_c) begin
                    tx_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx_out         = tx_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign bus.data_ready = ready_q;

endmodule
